// File: rtl/bc_uart_rx_ctrl.sv
// CPU-side UART receive controller: baud16x enable, FIFO-to-holding-register pop FSM, status and irq.
// Optional receive timeout is built when UART_RX_TIMEOUT_EN is defined.
module bc_uart_rx_ctrl #(
   parameter logic [15:0] DIV_RESET = 16'd53,
   parameter logic [9:0]  TMO_TICKS = 10'd640
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cs,
   input  logic       we,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       irq,
   output logic       baud16x_ce,
   output logic       rx_rd,
   output logic       rx_clear,
   input  logic [7:0] rx_do,
   input  logic       rx_data_present,
   input  logic       rx_full,
   input  logic       rx_frame_err,
   input  logic       rx_over_run,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FETCH = 2'd1, ST_SETTLE = 2'd2} state_e;

   state_e      state_q;
   logic [15:0] div_q, div_d, baud_cnt_q;
   logic [7:0]  hold_q, status;
   logic        hold_valid_q, ferr_q, ferr_d, frame_err_q;
   logic        ie_rx_q, ie_err_q;
   logic        rd_hold, rd_stat, wr_ctrl, wr_div_lo, wr_div_hi, do_clear, fetch, frame_rise;
   logic        tmo_flag, tmo_irq;

   assign rd_hold    = cs & ~we & (addr == 2'd0);
   assign rd_stat    = cs & ~we & (addr == 2'd1);
   assign wr_ctrl    = cs &  we & (addr == 2'd1);
   assign wr_div_lo  = cs &  we & (addr == 2'd2);
   assign wr_div_hi  = cs &  we & (addr == 2'd3);
   assign do_clear   = wr_ctrl & din[2];
   // A clear on the same edge suppresses the pop entirely, so the captured byte is discarded.
   assign fetch      = (state_q == ST_IDLE) & rx_data_present & ~hold_valid_q & ~do_clear;
   assign frame_rise = rx_frame_err & ~frame_err_q;
   assign status     = {irq, 2'b00, tmo_flag, rx_over_run, ferr_q, rx_full, hold_valid_q};
   assign dbg_state  = state_q;

   always_comb begin
      div_d = div_q;
      if (wr_div_lo) div_d[7:0]  = din;
      if (wr_div_hi) div_d[15:8] = din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q      <= DIV_RESET;
         baud_cnt_q <= DIV_RESET;
         baud16x_ce <= 1'b0;
      end else begin
         div_q <= div_d;
         if (wr_div_lo | wr_div_hi) begin
            baud_cnt_q <= div_d;
            baud16x_ce <= 1'b0;
         end else if (baud_cnt_q == 16'd0) begin
            baud_cnt_q <= div_q;
            baud16x_ce <= 1'b1;
         end else begin
            baud_cnt_q <= baud_cnt_q - 16'd1;
            baud16x_ce <= 1'b0;
         end
      end
   end

   // Byte is captured on the edge entering FETCH; rx_rd is high during FETCH so the receiver pops after.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rx_rd        <= 1'b0;
         hold_q       <= 8'h00;
         hold_valid_q <= 1'b0;
      end else begin
         rx_rd <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (fetch) begin
                  state_q <= ST_FETCH;
                  rx_rd   <= 1'b1;
                  hold_q  <= rx_do;
               end
            end
            ST_FETCH:  state_q <= ST_SETTLE;
            ST_SETTLE: state_q <= ST_IDLE;
            default:   state_q <= ST_IDLE;
         endcase
         if (do_clear) state_q <= ST_IDLE;

         if (do_clear)     hold_valid_q <= 1'b0;
         else if (fetch)   hold_valid_q <= 1'b1;
         else if (rd_hold) hold_valid_q <= 1'b0;
      end
   end

   always_comb begin
      ferr_d = ferr_q;
      if (do_clear)        ferr_d = 1'b0;
      else if (frame_rise) ferr_d = 1'b1;
      else if (rd_stat)    ferr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dout        <= 8'h00;
         irq         <= 1'b0;
         rx_clear    <= 1'b0;
         ie_rx_q     <= 1'b0;
         ie_err_q    <= 1'b0;
         ferr_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= rx_frame_err;
         ferr_q      <= ferr_d;
         rx_clear    <= do_clear;
         if (wr_ctrl) begin
            ie_rx_q  <= din[0];
            ie_err_q <= din[1];
         end
         if (cs & ~we) begin
            case (addr)
               2'd0:    dout <= hold_q;
               2'd1:    dout <= status;
               2'd2:    dout <= div_q[7:0];
               default: dout <= div_q[15:8];
            endcase
         end
         irq <= (ie_rx_q & hold_valid_q) | (ie_err_q & (ferr_q | rx_over_run)) | tmo_irq;
      end
   end

`ifdef UART_RX_TIMEOUT_EN
   logic [9:0] tmo_cnt_q;
   logic       tmo_q, ie_tmo_q, tmo_tick;

   assign tmo_tick = baud16x_ce & hold_valid_q & (tmo_cnt_q != TMO_TICKS);
   assign tmo_flag = tmo_q;
   assign tmo_irq  = ie_tmo_q & tmo_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_cnt_q <= 10'd0;
         tmo_q     <= 1'b0;
         ie_tmo_q  <= 1'b0;
      end else begin
         if (wr_ctrl) ie_tmo_q <= din[3];
         if (do_clear | fetch | rd_hold) tmo_cnt_q <= 10'd0;
         else if (tmo_tick)              tmo_cnt_q <= tmo_cnt_q + 10'd1;
         // The set only fires on the counting tick, so a saturated counter does not re-raise the flag.
         if (do_clear)                                           tmo_q <= 1'b0;
         else if (tmo_tick && (tmo_cnt_q + 10'd1 == TMO_TICKS))  tmo_q <= 1'b1;
         else if (rd_stat)                                       tmo_q <= 1'b0;
      end
   end
`else
   assign tmo_flag = 1'b0;
   assign tmo_irq  = 1'b0;
`endif

endmodule
